timer_share_ctrl: RTL
=====================

Name: timer_share_ctrl

Overview:
- Controller that shares one enabled up-counter (the team's basic count-with-enable/reset datapath) between N_REQ requesters.
- Each requester asks for a timed interval of programmable length.
- The block round-robin arbitrates, loads the winner's terminal count, sequences the counter's clear/enable, and returns a one-cycle done pulse to the winner.
- Sits between requesting FSMs and the shared timing counter.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CNT_W, 4, counter and terminal-count width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset: synchronous, active-high.
- req  input  N_REQ  level request per requester; held until done or abort.
- tc_in  input  N_REQ*CNT_W  terminal count per requester; slice i = bits [i*CNT_W +: CNT_W].
- gnt  output  N_REQ  one-hot grant, registered.
- done  output  N_REQ  one-cycle completion pulse to the winner, registered.
- busy  output  1  high when state is not IDLE.
- count  output  CNT_W  current shared counter value.

Behaviour:
- Reset:
  - state=IDLE; gnt=0; done=0; busy=0; count=0.
  - RR pointer=0; latched tc=0; owner=0.
  - Reset wins over every other event, including mid-RUN; no done is issued for an interrupted interval.
- States: IDLE, RUN, DONE.
- IDLE:
  - If any req bit is high, select the first set bit scanning from ptr upward, wrapping modulo N_REQ.
  - Latch the winner's tc_in slice into tc_q and the winner index into owner.
  - Clear the counter. Next state RUN; gnt[owner]=1 from the next cycle.
  - With no req: stay in IDLE, counter held at 0.
- RUN:
  - Counter enabled; increments by 1 each cycle starting at 0 in the first RUN cycle.
  - When count==tc_q in a RUN cycle: next state DONE, counter holds.
  - tc_q=0 gives exactly one RUN cycle.
  - tc_q=2^CNT_W-1 reaches the maximum without wrap; the counter never wraps in normal operation.
  - Abort: if req[owner]==0 in any RUN cycle, the next state is IDLE. gnt drops, no done pulse, counter cleared, ptr=owner+1 mod N_REQ.
  - Abort takes priority over completion in the same cycle.
  - Changes on tc_in or on other req bits during RUN are ignored.
- DONE:
  - One cycle only: done[owner]=1, gnt=0, ptr=owner+1 mod N_REQ, counter cleared.
  - Next state IDLE unconditionally.
  - The requester must drop req during the DONE cycle; req still high in IDLE is a new request.
- Latency: req sampled in IDLE at cycle 0 -> gnt at cycle 1 -> done at cycle tc+2 -> next grant earliest at cycle tc+4.
- Outputs:
  - gnt and done are never high in the same cycle.
  - At most one bit of gnt is high; at most one bit of done is high.
  - busy=1 in RUN and DONE.

Decomposition:
- Shared package timer_share_pkg holds:
  - state enum {IDLE, RUN, DONE}, 2 bits;
  - typedef cnt_t = logic[CNT_W-1:0];
  - a function for round-robin next-index.
- One natural sub-module: share_counter. It is a CNT_W-bit up-counter with synchronous clear (rst or clr) and enable, and is instantiated once.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Single request: req=4'b0001, tc_in[3:0]=3, held until done -> gnt[0] cycles 1-4, count 0,1,2,3, done[0]=1 at cycle 5 only, busy low at cycle 6.
- Round-robin fairness: req=4'b0101 held continuously, re-raised after each done, all tc=1 -> grant order 0,2,0,2; ptr wraps correctly with req=4'b1001, giving order 0,3,0,3.
- Boundary counts:
  - tc=0 -> exactly one RUN cycle, done at cycle 2.
  - tc=15 -> count reaches 15, no wrap, done at cycle 17.
- Abort: req[1] granted with tc=9, dropped when count=4 -> IDLE next cycle, no done, count=0, and the next pending req[2] is granted before req[1].
- Reset mid-RUN: rst=1 while count=5 -> next cycle gnt=0, done=0, busy=0, count=0, ptr=0; after reset, req=4'b1111 -> grant to requester 0.

Source files
------------

// File: rtl/timer_share_pkg.sv
// rtl/timer_share_pkg.sv - shared types and round-robin helpers for the timer share controller
package timer_share_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_CNT_W = 4;
  localparam int IDX_W     = 3;
  localparam int MAX_REQ   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [DEF_CNT_W-1:0] cnt_t;

  // First set request at or after ptr, wrapping modulo n; returns ptr when none is set.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req_v,
                                               input logic [IDX_W-1:0]   ptr,
                                               input int                 n);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && req_v[idx[IDX_W-1:0]]) begin
        pick  = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] rr_inc(input logic [IDX_W-1:0] idx, input int n);
    int t;
    t = int'(idx) + 1;
    if (t >= n) t = 0;
    return t[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/share_counter.sv
// rtl/share_counter.sv - shared up-counter with synchronous clear and enable
module share_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/timer_share_ctrl.sv
// rtl/timer_share_ctrl.sv - round-robin sharing of one interval counter among N_REQ requesters
module timer_share_ctrl
  import timer_share_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] tc_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       count
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_tc;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_done;

  logic [MAX_REQ-1:0] w_req8;
  logic [IDX_W-1:0]   w_pick;
  logic [CNT_W-1:0]   w_tc_sel;
  logic [CNT_W-1:0]   w_count;
  logic               w_abort;
  logic               w_hit;
  logic               w_clr;
  logic               w_en;

  assign w_req8   = MAX_REQ'(req);
  assign w_pick   = rr_pick(w_req8, r_ptr, N_REQ);
  assign w_tc_sel = tc_in[int'(w_pick)*CNT_W +: CNT_W];
  assign w_abort  = (r_state == RUN) && !w_req8[r_owner];
  assign w_hit    = (w_count == r_tc);

  // Counter runs only while RUN and not yet at terminal count; it is zeroed everywhere else.
  assign w_clr = (r_state != RUN) || w_abort;
  assign w_en  = (r_state == RUN) && !w_abort && !w_hit;

  share_counter #(.CNT_W(CNT_W)) u_counter (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_tc    <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= '0;
          if (|req) begin
            r_owner <= w_pick;
            r_tc    <= w_tc_sel;
            r_gnt   <= N_REQ'(1) << w_pick;
            r_state <= RUN;
          end
        end
        RUN: begin
          // Abort outranks completion when both land in the same cycle.
          if (w_abort) begin
            r_gnt   <= '0;
            r_ptr   <= rr_inc(r_owner, N_REQ);
            r_state <= IDLE;
          end else if (w_hit) begin
            r_gnt   <= '0;
            r_done  <= N_REQ'(1) << r_owner;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= '0;
          r_ptr   <= rr_inc(r_owner, N_REQ);
          r_state <= IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_done  <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign done  = r_done;
  assign busy  = (r_state != IDLE);
  assign count = w_count;

endmodule
